ir_remote_tx: RTL

- Transmitter side of the 3-bit IR remote link. Takes a button code from the game/test logic and serialises it onto an idle-high single-wire line (irda) as one frame: a low start segment, then bit2, bit1, bit0, then a high guard gap.
- Segment windows are sized so that the existing remote receiver's fixed sample points fall well inside each bit window.
- Used for loopback testing of the receiver and as the IR emitter driver on the board.

---
 rtl/ir_remote_pkg.sv | 38 +++
 rtl/ir_remote_tx.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ir_remote_pkg.sv
// Shared definitions for the 3-bit IR remote link (transmitter and receiver).
// Button codes, code validity check, default frame timing and tx FSM states.
package ir_remote_pkg;

    localparam logic [2:0] BTN_A = 3'b001;
    localparam logic [2:0] BTN_B = 3'b010;
    localparam logic [2:0] BTN_C = 3'b011;
    localparam logic [2:0] BTN_D = 3'b100;
    localparam logic [2:0] BTN_E = 3'b110;

    // Frame timing in clock cycles, measured from frame cycle 0.
    localparam int DEF_T_START  = 8;
    localparam int DEF_T_B2_END = 18;
    localparam int DEF_T_B1_END = 30;
    localparam int DEF_T_B0_END = 46;
    localparam int DEF_T_GAP    = 16;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT2,
        S_BIT1,
        S_BIT0,
        S_GAP
    } tx_state_e;

    function automatic logic is_valid_code(input logic [2:0] c);
        logic ok;
        case (c)
            BTN_A, BTN_B, BTN_C,
            BTN_D, BTN_E: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ir_remote_tx.sv
// IR remote transmitter: serialises a 3-bit button code onto idle-high irda.
// Ports: clk, rst (async, active-high), start, code[2:0] in;
//        irda, busy, done, err, frame_cnt[1:0] out.
module ir_remote_tx
    import ir_remote_pkg::*;
#(
    parameter int T_START  = DEF_T_START,
    parameter int T_B2_END = DEF_T_B2_END,
    parameter int T_B1_END = DEF_T_B1_END,
    parameter int T_B0_END = DEF_T_B0_END,
    parameter int T_GAP    = DEF_T_GAP,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] code,
    output logic       irda,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] frame_cnt
);

    // Last timer value of each segment; the timer runs continuously
    // from 0 through the whole frame and gap.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(T_START - 1);
    localparam logic [CNT_W-1:0] B2_LAST    = CNT_W'(T_B2_END - 1);
    localparam logic [CNT_W-1:0] B1_LAST    = CNT_W'(T_B1_END - 1);
    localparam logic [CNT_W-1:0] B0_LAST    = CNT_W'(T_B0_END - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_B0_END + T_GAP - 1);

    tx_state_e        state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [2:0]       code_q, code_n;
    logic             irda_n;
    logic             busy_n;
    logic             done_n;
    logic             err_n;
    logic [1:0]       cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            code_q    <= '0;
            irda      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            code_q    <= code_n;
            irda      <= irda_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            frame_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        code_n  = code_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        cnt_n   = frame_cnt;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_valid_code(code)) begin
                        state_n = S_START;
                        timer_n = '0;
                        code_n  = code;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_START: begin
                timer_n = timer + 1'b1;
                if (timer == START_LAST)
                    state_n = S_BIT2;
            end
            S_BIT2: begin
                timer_n = timer + 1'b1;
                if (timer == B2_LAST)
                    state_n = S_BIT1;
            end
            S_BIT1: begin
                timer_n = timer + 1'b1;
                if (timer == B1_LAST)
                    state_n = S_BIT0;
            end
            S_BIT0: begin
                timer_n = timer + 1'b1;
                if (timer == B0_LAST)
                    state_n = S_GAP;
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                    done_n  = 1'b1;
                    cnt_n   = frame_cnt + 2'd1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // irda is registered from the next state so the line changes only on
    // posedge and already shows segment n during frame cycle n.
    always_comb begin
        irda_n = 1'b1;
        unique case (state_n)
            S_START: irda_n = 1'b0;
            S_BIT2:  irda_n = code_n[2];
            S_BIT1:  irda_n = code_n[1];
            S_BIT0:  irda_n = code_n[0];
            default: irda_n = 1'b1;
        endcase
    end

    assign busy_n = (state_n != S_IDLE);

endmodule
